// File: rtl/y86_decode_wb_param.sv
`default_nettype none
// ----------------------------------------------------------------------------
// y86_decode_wb_param : Y86-64 decode/writeback stage with forwarding, E register
// Rev 1.0
// ----------------------------------------------------------------------------
module y86_decode_wb_param #(
  parameter int DATA_W     = 64,
  parameter int NREG       = 15,
  parameter int RID_W      = 4,
  parameter int RSP_ID     = 4,
  parameter int INIT_INDEX = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [3:0]             D_stat,
  input  logic [3:0]             D_icode,
  input  logic [3:0]             D_ifun,
  input  logic [RID_W-1:0]       D_rA,
  input  logic [RID_W-1:0]       D_rB,
  input  logic [DATA_W-1:0]      D_valC,
  input  logic [DATA_W-1:0]      D_valP,
  input  logic                   E_stall,
  input  logic                   E_bubble,
  input  logic [RID_W-1:0]       e_dstE,
  input  logic [RID_W-1:0]       M_dstE,
  input  logic [RID_W-1:0]       M_dstM,
  input  logic [RID_W-1:0]       W_dstE,
  input  logic [RID_W-1:0]       W_dstM,
  input  logic [DATA_W-1:0]      e_valE,
  input  logic [DATA_W-1:0]      M_valE,
  input  logic [DATA_W-1:0]      m_valM,
  input  logic [DATA_W-1:0]      W_valE,
  input  logic [DATA_W-1:0]      W_valM,
  output logic [3:0]             E_stat,
  output logic [3:0]             E_icode,
  output logic [3:0]             E_ifun,
  output logic [DATA_W-1:0]      E_valC,
  output logic [DATA_W-1:0]      E_valA,
  output logic [DATA_W-1:0]      E_valB,
  output logic [RID_W-1:0]       E_dstE,
  output logic [RID_W-1:0]       E_dstM,
  output logic [RID_W-1:0]       E_srcA,
  output logic [RID_W-1:0]       E_srcB,
  output logic [RID_W-1:0]       d_srcA,
  output logic [RID_W-1:0]       d_srcB,
  output logic                   load_use,
  output logic [NREG*DATA_W-1:0] reg_dump
);

  localparam logic [RID_W-1:0] c_NONE = '1;
  localparam logic [RID_W-1:0] c_RSP  = RID_W'(RSP_ID);
  localparam logic [3:0]       c_AOK  = 4'b1000;
  localparam logic [3:0]       c_NOP  = 4'h1;

  logic [DATA_W-1:0] r_regs [NREG];

  logic [RID_W-1:0]  w_srcA, w_srcB, w_dstE, w_dstM;
  logic [DATA_W-1:0] w_rvalA, w_rvalB, w_fwdA, w_fwdB;

  always_comb begin
    w_srcA = c_NONE;
    w_srcB = c_NONE;
    w_dstE = c_NONE;
    w_dstM = c_NONE;
    case (D_icode)
      4'h2: begin w_srcA = D_rA; w_dstE = D_rB; end
      4'h3: begin w_dstE = D_rB; end
      4'h4: begin w_srcA = D_rA; w_srcB = D_rB; end
      4'h5: begin w_srcB = D_rB; w_dstM = D_rA; end
      4'h6: begin w_srcA = D_rA; w_srcB = D_rB; w_dstE = D_rB; end
      4'h8: begin w_srcB = c_RSP; w_dstE = c_RSP; end
      4'h9: begin w_srcA = c_RSP; w_srcB = c_RSP; w_dstE = c_RSP; end
      4'hA: begin w_srcA = D_rA; w_srcB = c_RSP; w_dstE = c_RSP; end
      4'hB: begin w_srcA = c_RSP; w_srcB = c_RSP; w_dstE = c_RSP; w_dstM = D_rA; end
      default: ;
    endcase
  end

  // Out-of-range and NONE IDs never match an index, so they read as zero.
  always_comb begin
    w_rvalA = '0;
    w_rvalB = '0;
    for (int i = 0; i < NREG; i++) begin
      if (w_srcA != c_NONE && w_srcA == RID_W'(i)) w_rvalA = r_regs[i];
      if (w_srcB != c_NONE && w_srcB == RID_W'(i)) w_rvalB = r_regs[i];
    end
  end

  always_comb begin
    if (D_icode == 4'h7 || D_icode == 4'h8)   w_fwdA = D_valP;
    else if (w_srcA != c_NONE && w_srcA == e_dstE) w_fwdA = e_valE;
    else if (w_srcA != c_NONE && w_srcA == M_dstM) w_fwdA = m_valM;
    else if (w_srcA != c_NONE && w_srcA == M_dstE) w_fwdA = M_valE;
    else if (w_srcA != c_NONE && w_srcA == W_dstM) w_fwdA = W_valM;
    else if (w_srcA != c_NONE && w_srcA == W_dstE) w_fwdA = W_valE;
    else                                           w_fwdA = w_rvalA;
  end

  always_comb begin
    if (w_srcB != c_NONE && w_srcB == e_dstE)      w_fwdB = e_valE;
    else if (w_srcB != c_NONE && w_srcB == M_dstM) w_fwdB = m_valM;
    else if (w_srcB != c_NONE && w_srcB == M_dstE) w_fwdB = M_valE;
    else if (w_srcB != c_NONE && w_srcB == W_dstM) w_fwdB = W_valM;
    else if (w_srcB != c_NONE && w_srcB == W_dstE) w_fwdB = W_valE;
    else                                           w_fwdB = w_rvalB;
  end

  // Port M is written after port E so it wins on a same-register collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++)
        r_regs[i] <= (INIT_INDEX != 0) ? DATA_W'(i) : '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (W_dstE != c_NONE && W_dstE == RID_W'(i)) r_regs[i] <= W_valE;
        if (W_dstM != c_NONE && W_dstM == RID_W'(i)) r_regs[i] <= W_valM;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || E_bubble) begin
      E_stat  <= c_AOK;
      E_icode <= c_NOP;
      E_ifun  <= 4'h0;
      E_valC  <= '0;
      E_valA  <= '0;
      E_valB  <= '0;
      E_dstE  <= c_NONE;
      E_dstM  <= c_NONE;
      E_srcA  <= c_NONE;
      E_srcB  <= c_NONE;
    end else if (!E_stall) begin
      E_stat  <= D_stat;
      E_icode <= D_icode;
      E_ifun  <= D_ifun;
      E_valC  <= D_valC;
      E_valA  <= w_fwdA;
      E_valB  <= w_fwdB;
      E_dstE  <= w_dstE;
      E_dstM  <= w_dstM;
      E_srcA  <= w_srcA;
      E_srcB  <= w_srcB;
    end
  end

  assign d_srcA   = w_srcA;
  assign d_srcB   = w_srcB;
  assign load_use = (E_icode == 4'h5 || E_icode == 4'hB) && (E_dstM != c_NONE) &&
                    (E_dstM == w_srcA || E_dstM == w_srcB);

  for (genvar gi = 0; gi < NREG; gi++) begin : g_dump
    assign reg_dump[gi*DATA_W +: DATA_W] = r_regs[gi];
  end

endmodule
`default_nettype wire

// File: tb/tb_y86_decode_wb_param.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_y86_decode_wb_param : directed plus randomized check against a reference model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_y86_decode_wb_param;

  localparam int W = 64;
  localparam int N = 15;
  localparam logic [3:0] NONE = 4'hF;

  logic clk = 1'b0;
  logic reset;
  logic [3:0] D_stat, D_icode, D_ifun, D_rA, D_rB;
  logic [W-1:0] D_valC, D_valP;
  logic E_stall, E_bubble;
  logic [3:0] e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
  logic [W-1:0] e_valE, M_valE, m_valM, W_valE, W_valM;
  logic [3:0] E_stat, E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB, d_srcA, d_srcB;
  logic [W-1:0] E_valC, E_valA, E_valB;
  logic load_use;
  logic [N*W-1:0] reg_dump;

  int total = 0;
  int bad = 0;

  y86_decode_wb_param #(.DATA_W(W), .NREG(N), .RID_W(4), .RSP_ID(4), .INIT_INDEX(1)) dut (
    .clk(clk), .reset(reset), .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun),
    .D_rA(D_rA), .D_rB(D_rB), .D_valC(D_valC), .D_valP(D_valP),
    .E_stall(E_stall), .E_bubble(E_bubble),
    .e_dstE(e_dstE), .M_dstE(M_dstE), .M_dstM(M_dstM), .W_dstE(W_dstE), .W_dstM(W_dstM),
    .e_valE(e_valE), .M_valE(M_valE), .m_valM(m_valM), .W_valE(W_valE), .W_valM(W_valM),
    .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun), .E_valC(E_valC),
    .E_valA(E_valA), .E_valB(E_valB), .E_dstE(E_dstE), .E_dstM(E_dstM),
    .E_srcA(E_srcA), .E_srcB(E_srcB), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .load_use(load_use), .reg_dump(reg_dump)
  );

  always #5 clk = ~clk;

  // Reference state
  logic [W-1:0] m_rf [N];
  logic [3:0]   mE_stat, mE_icode, mE_ifun, mE_dstE, mE_dstM, mE_srcA, mE_srcB;
  logic [W-1:0] mE_valC, mE_valA, mE_valB;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Register usage per instruction class, taken straight from the ISA table.
  task automatic ref_decode(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                            output logic [3:0] sa, output logic [3:0] sb,
                            output logic [3:0] de, output logic [3:0] dm);
    sa = NONE; sb = NONE; de = NONE; dm = NONE;
    if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) sa = ra;
    if (ic inside {4'h9, 4'hB})             sa = 4'd4;
    if (ic inside {4'h4, 4'h5, 4'h6})       sb = rb;
    if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) sb = 4'd4;
    if (ic inside {4'h2, 4'h3, 4'h6})       de = rb;
    if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) de = 4'd4;
    if (ic == 4'h5)                         dm = ra;
    if (ic == 4'hB)                         dm = ra;
  endtask

  function automatic logic [W-1:0] ref_operand(input logic [3:0] src);
    logic [3:0]   dsts [5];
    logic [W-1:0] vals [5];
    dsts = '{e_dstE, M_dstM, M_dstE, W_dstM, W_dstE};
    vals = '{e_valE, m_valM, M_valE, W_valM, W_valE};
    if (src == NONE) return '0;
    foreach (dsts[k]) if (dsts[k] == src) return vals[k];
    return (int'(src) < N) ? m_rf[src] : '0;
  endfunction

  task automatic ref_nop();
    mE_stat = 4'b1000; mE_icode = 4'h1; mE_ifun = 4'h0;
    mE_valC = '0; mE_valA = '0; mE_valB = '0;
    mE_dstE = NONE; mE_dstM = NONE; mE_srcA = NONE; mE_srcB = NONE;
  endtask

  task automatic idle();
    reset = 0; E_stall = 0; E_bubble = 0;
    D_stat = 4'b1000; D_icode = 4'h1; D_ifun = 0; D_rA = NONE; D_rB = NONE;
    D_valC = 0; D_valP = 0;
    e_dstE = NONE; M_dstE = NONE; M_dstM = NONE; W_dstE = NONE; W_dstM = NONE;
    e_valE = 0; M_valE = 0; m_valM = 0; W_valE = 0; W_valM = 0;
  endtask

  // Checks combinational outputs, advances one edge in model and DUT, checks state.
  task automatic do_cycle();
    logic [3:0] sa, sb, de, dm;
    logic [W-1:0] va, vb;
    logic lu;
    #1;
    ref_decode(D_icode, D_rA, D_rB, sa, sb, de, dm);
    lu = (mE_icode == 4'h5 || mE_icode == 4'hB) && mE_dstM != NONE &&
         (mE_dstM == sa || mE_dstM == sb);
    check("d_srcA", W'(d_srcA), W'(sa));
    check("d_srcB", W'(d_srcB), W'(sb));
    check("load_use", W'(load_use), W'(lu));
    va = (D_icode == 4'h7 || D_icode == 4'h8) ? D_valP : ref_operand(sa);
    vb = ref_operand(sb);
    if (reset) begin
      for (int i = 0; i < N; i++) m_rf[i] = W'(i);
      ref_nop();
    end else begin
      if (W_dstE != NONE && int'(W_dstE) < N) m_rf[W_dstE] = W_valE;
      if (W_dstM != NONE && int'(W_dstM) < N) m_rf[W_dstM] = W_valM;
      if (E_bubble) ref_nop();
      else if (!E_stall) begin
        mE_stat = D_stat; mE_icode = D_icode; mE_ifun = D_ifun; mE_valC = D_valC;
        mE_valA = va; mE_valB = vb; mE_dstE = de; mE_dstM = dm; mE_srcA = sa; mE_srcB = sb;
      end
    end
    @(posedge clk);
    #1;
    check("E_stat", W'(E_stat), W'(mE_stat));
    check("E_icode", W'(E_icode), W'(mE_icode));
    check("E_ifun", W'(E_ifun), W'(mE_ifun));
    check("E_valC", E_valC, mE_valC);
    check("E_valA", E_valA, mE_valA);
    check("E_valB", E_valB, mE_valB);
    check("E_dstE", W'(E_dstE), W'(mE_dstE));
    check("E_dstM", W'(E_dstM), W'(mE_dstM));
    check("E_srcA", W'(E_srcA), W'(mE_srcA));
    check("E_srcB", W'(E_srcB), W'(mE_srcB));
    for (int i = 0; i < N; i++) check("reg_dump", reg_dump[i*W +: W], m_rf[i]);
  endtask

  function automatic logic [3:0] rnd_id();
    return ($urandom_range(0, 3) == 0) ? NONE : 4'($urandom_range(0, 14));
  endfunction

  function automatic logic [W-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    for (int i = 0; i < N; i++) m_rf[i] = '0;
    ref_nop();
    idle();
    @(posedge clk);
    #1;

    // Reset establishes indexed registers and a nop in E
    reset = 1;
    do_cycle();
    idle();
    check("rst_icode", W'(E_icode), 64'h1);
    check("rst_dstE", W'(E_dstE), 64'hF);
    check("rst_r14", reg_dump[14*W +: W], 64'd14);

    // OPq with no forwarding
    D_icode = 4'h6; D_rA = 4'd2; D_rB = 4'd3;
    do_cycle();
    check("opq_valA", E_valA, 64'd2);
    check("opq_valB", E_valB, 64'd3);
    check("opq_dstE", W'(E_dstE), 64'd3);

    // e-stage forward beats M-stage forward
    e_dstE = 4'd2; e_valE = 64'd99; M_dstE = 4'd2; M_valE = 64'd55;
    do_cycle();
    check("prio_valA", E_valA, 64'd99);
    idle();

    // Same-register writeback: M port wins
    W_dstE = 4'd4; W_dstM = 4'd4; W_valE = 64'h100; W_valM = 64'h7;
    do_cycle();
    idle();
    check("wb_r4", reg_dump[4*W +: W], 64'h7);

    // Load-use: mrmovq into r3, then OPq reading r3 under stall
    D_icode = 4'h5; D_rA = 4'd3; D_rB = 4'd1; D_valC = 64'h20;
    do_cycle();
    D_icode = 4'h6; D_rA = 4'd3; D_rB = 4'd2; D_valC = 0; E_stall = 1;
    #1;
    check("lu_flag", W'(load_use), 64'd1);
    do_cycle();
    check("stall_icode", W'(E_icode), 64'h5);
    check("stall_dstM", W'(E_dstM), 64'd3);
    idle();

    // call with bubble, then without
    D_icode = 4'h8; D_valP = 64'h40; E_bubble = 1;
    do_cycle();
    check("bub_icode", W'(E_icode), 64'h1);
    E_bubble = 0;
    do_cycle();
    check("call_valA", E_valA, 64'h40);
    idle();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      reset    = ($urandom_range(0, 60) == 0);
      E_bubble = ($urandom_range(0, 9) == 0);
      E_stall  = ($urandom_range(0, 6) == 0);
      D_stat   = 4'($urandom_range(0, 15));
      D_icode  = 4'($urandom_range(0, 12));
      D_ifun   = 4'($urandom_range(0, 15));
      D_rA     = 4'($urandom_range(0, 15));
      D_rB     = 4'($urandom_range(0, 15));
      D_valC   = rnd64();
      D_valP   = rnd64();
      e_dstE = rnd_id(); M_dstE = rnd_id(); M_dstM = rnd_id();
      W_dstE = rnd_id(); W_dstM = rnd_id();
      e_valE = rnd64(); M_valE = rnd64(); m_valM = rnd64();
      W_valE = rnd64(); W_valM = rnd64();
      do_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/y86_decode_wb_param.md
# y86_decode_wb_param

Parametrised decode/writeback stage for the Y86-64 pipeline: decodes source and destination register IDs from the D-stage fields and reads operands from a register file. Operands are resolved through a five-source forwarding network and latched into the E pipeline register, which supports stall and bubble. The register file has two independent write ports (E and M) with defined same-register priority, synchronous reset, and load-use hazard detection for the pipeline control unit.

## Interface
- DATA_W, 64, operand/register width
- NREG, 15, number of architectural registers (IDs 0..NREG-1)
- RID_W, 4, register-ID width; ID all-ones = NONE (no register)
- RSP_ID, 4, stack-pointer register ID
- INIT_INDEX, 1, 1: reset loads register[i]=i; 0: reset loads 0
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- D_stat  in  4  D-stage status, [0:3] encoding, AOK=4'b1000
- D_icode, D_ifun  in  4 each  D-stage instruction code/function
- D_rA, D_rB  in  RID_W each  register specifiers
- D_valC, D_valP  in  DATA_W each  constant, next PC
- E_stall, E_bubble  in  1 each  E-register hold / inject nop
- e_dstE, M_dstE, M_dstM, W_dstE, W_dstM  in  RID_W each  forwarding/writeback destinations
- e_valE, M_valE, m_valM, W_valE, W_valM  in  DATA_W each  forwarding/writeback values
- E_stat  out  4; E_icode, E_ifun  out  4 each; E_valC, E_valA, E_valB  out  DATA_W each; E_dstE, E_dstM, E_srcA, E_srcB  out  RID_W each  E pipeline register
- d_srcA, d_srcB  out  RID_W each  combinational decode sources
- load_use  out  1  combinational load-use hazard flag
- reg_dump  out  NREG*DATA_W  register i at bits [i*DATA_W +: DATA_W], current array state

## Operation
- Decode (combinational, every path assigns all four IDs, default NONE):
  - cmovq(2): srcA=rA, dstE=rB
  - irmovq(3): dstE=rB
  - rmmovq(4): srcA=rA, srcB=rB
  - mrmovq(5): srcB=rB, dstM=rA
  - OPq(6): srcA=rA, srcB=rB, dstE=rB
  - call(8): srcB=dstE=RSP
  - ret(9): srcA=srcB=dstE=RSP
  - pushq(A): srcA=rA, srcB=dstE=RSP
  - popq(B): srcA=srcB=dstE=RSP, dstM=rA
  - all other icodes: all NONE
- Read: ID NONE or ≥NREG reads 0.
- valA select, first match wins: icode 7/8 → D_valP; e_dstE → e_valE; M_dstM → m_valM; M_dstE → M_valE; W_dstM → W_valM; W_dstE → W_valE; else register file. valB uses the same chain without the D_valP term. A source never matches NONE.
- Writeback on each edge: W_dstE≠NONE writes W_valE; W_dstM≠NONE writes W_valM. If both name the same register, W_valM wins. IDs ≥NREG and NONE are ignored. No icode gating: execute sets dstE=NONE for untaken cmov.
- load_use = (E_icode∈{5,B}) & E_dstM≠NONE & (E_dstM==d_srcA | E_dstM==d_srcB). Flag only; the control unit stalls.

## Timing
- Edge priority: reset > E_bubble > E_stall > load.
- Reset and bubble set E to: stat 4'b1000, icode 1, ifun 0, data 0, all IDs NONE. Reset also initialises the register file per INIT_INDEX; reset_dump reflects it the next cycle.
- Stall holds every E field.
- Load: E takes D fields, forwarded valA/valB and decoded IDs in one cycle; decode-to-E latency is 1.
- A write at edge N is visible in the array after N. A same-cycle read of that register resolves through the W forwarding terms, so decode never sees a stale value.
- Reset mid-operation discards in-flight E contents; writebacks presented in the reset cycle are dropped.

## Test plan
- Reset with INIT_INDEX=1 → reg_dump[i]=i for i=0..14; E_icode=1, all E IDs 4'hF.
- OPq rA=2 rB=3, no forwarding → next cycle E_valA=2, E_valB=3, E_dstE=3.
- OPq rA=2 with e_dstE=2/e_valE=99 and M_dstE=2/M_valE=55 → E_valA=99 (priority).
- popq writeback W_dstE=4, W_dstM=4, W_valE=0x100, W_valM=0x7 → register[4]=0x7.
- E_icode=5, E_dstM=3, decode OPq rA=3 → load_use=1; with E_stall=1, E holds all fields.
- call with D_valP=0x40 and E_bubble=1 asserted together → E is a nop. The next cycle, with no bubble, E_valA=0x40.
